// File: rtl/carryout_gen_pkg.sv
// Shared constants for the DSP slice carry-out path: SIMD modes, ALUMODE
// encodings and per-mode lane masks.
package carryout_gen_pkg;

   localparam int ONE48  = 0;
   localparam int TWO24  = 1;
   localparam int FOUR12 = 2;

   localparam logic [3:0] ALUMODE_ADD      = 4'b0000;
   localparam logic [3:0] ALUMODE_ADD_ALT  = 4'b0010;
   localparam logic [3:0] ALUMODE_SUB_ZMXY = 4'b0011;
   localparam logic [3:0] ALUMODE_SUB_XYMZ = 4'b0001;
   localparam logic [3:0] ALUMODE_SUB_ALT  = 4'b0011;

   localparam logic [3:0] MASK_ONE48  = 4'b1000;
   localparam logic [3:0] MASK_TWO24  = 4'b1010;
   localparam logic [3:0] MASK_FOUR12 = 4'b1111;

   localparam int CARRY_REG_W = 6;

   // Unsupported SIMD encodings fall back to the single 48-bit lane.
   function automatic logic [3:0] lane_mask(input int simd);
      case (simd)
         TWO24:   return MASK_TWO24;
         FOUR12:  return MASK_FOUR12;
         ONE48:   return MASK_ONE48;
         default: return MASK_ONE48;
      endcase
   endfunction

endpackage

// File: rtl/carryout_reg.sv
// Carry-out register with synchronous reset (priority over CE) and a
// parameterised combinational bypass, built as a dff followed by a 2:1 mux.
module carryout_reg #(
   parameter bit bypass_p = 1'b0,
   parameter int width_p  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   input  logic [width_p-1:0] d,
   output logic [width_p-1:0] q
);

   logic [width_p-1:0] q_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= '0;
      end else if (ce) begin
         q_r <= d;
      end
   end

   assign q = bypass_p ? d : q_r;

endmodule

// File: rtl/carryout_gen.sv
// Carry-out generation for the DSP slice: lane masking and subtract/logic
// correction of the post-adder carries, then an optional output register.
module carryout_gen
   import carryout_gen_pkg::*;
#(
   parameter int carryoutreg_p = 1,
   parameter int use_simd_p    = 0
) (
   input  logic       clk,
   input  logic       RSTALLCARRYIN,
   input  logic       CECARRYIN,
   input  logic [3:0] alu_carry,
   input  logic [3:0] alumode,
   input  logic       mult_sign,
   output logic [3:0] CARRYOUT,
   output logic       CARRYCASCOUT,
   output logic       MULTSIGNOUT
);

   localparam logic [3:0] lane_mask_c = lane_mask(use_simd_p);
   localparam bit         bypass_c    = (carryoutreg_p == 0);

   logic [3:0]             corrected;
   logic [3:0]             cout_next;
   logic                   cascade_next;
   logic [CARRY_REG_W-1:0] reg_d;
   logic [CARRY_REG_W-1:0] reg_q;

   // Subtract forms report the complement of the raw carry; logic modes
   // have no meaningful carry and drive zero.
   always_comb begin
      corrected = '0;
      case (alumode)
         ALUMODE_ADD, ALUMODE_ADD_ALT:     corrected = alu_carry;
         ALUMODE_SUB_XYMZ, ALUMODE_SUB_ZMXY: corrected = ~alu_carry;
         default:                          corrected = '0;
      endcase
   end

   // The AND with the mask also keeps unknowns on unused lanes off CARRYOUT.
   assign cout_next    = lane_mask_c & corrected;
   assign cascade_next = corrected[3];
   assign reg_d        = {mult_sign, cascade_next, cout_next};

   carryout_reg #(
      .bypass_p (bypass_c),
      .width_p  (CARRY_REG_W)
   ) u_carryout_reg (
      .clk (clk),
      .rst (RSTALLCARRYIN),
      .ce  (CECARRYIN),
      .d   (reg_d),
      .q   (reg_q)
   );

   assign CARRYOUT     = reg_q[3:0];
   assign CARRYCASCOUT = reg_q[4];
   assign MULTSIGNOUT  = reg_q[5];

endmodule

// File: tb/tb_carryout_gen.sv
// Bench for carryout_gen: registered instances for every SIMD setting plus a
// bypass instance, checked against vector tables, hand sequences and a model.
module tb_carryout_gen;

   logic       clk;
   logic       rst;
   logic       ce;
   logic [3:0] alu_carry;
   logic [3:0] alumode;
   logic       mult_sign;

   // Instances 0..3: registered, use_simd_p = 0,1,2,3. Instance 4: bypass, FOUR12.
   logic [3:0] co   [5];
   logic       cc   [5];
   logic       mso  [5];

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [5:0] m_state [4];
   logic [5:0] exp_q[$];

   for (genvar g = 0; g < 4; g++) begin : g_reg
      carryout_gen #(
         .carryoutreg_p (1),
         .use_simd_p    (g)
      ) u_dut (
         .clk           (clk),
         .RSTALLCARRYIN (rst),
         .CECARRYIN     (ce),
         .alu_carry     (alu_carry),
         .alumode       (alumode),
         .mult_sign     (mult_sign),
         .CARRYOUT      (co[g]),
         .CARRYCASCOUT  (cc[g]),
         .MULTSIGNOUT   (mso[g])
      );
   end

   carryout_gen #(
      .carryoutreg_p (0),
      .use_simd_p    (2)
   ) u_byp (
      .clk           (clk),
      .RSTALLCARRYIN (rst),
      .CECARRYIN     (ce),
      .alu_carry     (alu_carry),
      .alumode       (alumode),
      .mult_sign     (mult_sign),
      .CARRYOUT      (co[4]),
      .CARRYCASCOUT  (cc[4]),
      .MULTSIGNOUT   (mso[4])
   );

   // Clock and reset defaults
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: a lane is live if it is the top lane, or the mode splits the
   // word there. Add keeps the carry, subtract gives 1 - carry, logic gives 0.
   function automatic logic [5:0] model_next(input int simd, input logic [3:0] am,
                                             input logic [3:0] c, input logic ms);
      logic [3:0] cout;
      logic       casc;
      int         b;
      cout = '0;
      for (int i = 0; i < 4; i++) begin
         if (am > 4'd3)          b = 0;
         else if (am == 4'd1 || am == 4'd3) b = 1 - int'(c[i]);
         else                    b = int'(c[i]);
         if (i == 3 || simd == 2 || (simd == 1 && i == 1))
            cout[i] = (b == 1);
      end
      if (am > 4'd3)                    casc = 1'b0;
      else if (am == 4'd1 || am == 4'd3) casc = ~c[3];
      else                              casc = c[3];
      return {ms, casc, cout};
   endfunction

   function automatic logic [5:0] dut_out(input int k);
      return {mso[k], cc[k], co[k]};
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic drive(input logic r, input logic e, input logic [3:0] am,
                        input logic [3:0] c, input logic ms);
      rst       = r;
      ce        = e;
      alumode   = am;
      alu_carry = c;
      mult_sign = ms;
   endtask

   // Advance the model for the coming edge, then take the edge.
   task automatic tick;
      for (int k = 0; k < 4; k++) begin
         if (rst)     m_state[k] = '0;
         else if (ce) m_state[k] = model_next(k, alumode, alu_carry, mult_sign);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string name);
      for (int k = 0; k < 4; k++)
         check($sformatf("%s_reg%0d", name, k), dut_out(k), m_state[k]);
   endtask

   typedef struct {
      logic [3:0] am;
      logic [3:0] c;
      logic       ms;
      logic [5:0] exp_one48;
      logic [5:0] exp_two24;
      logic [5:0] exp_four12;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{4'b0000, 4'b1111, 1'b0, 6'b011000, 6'b011010, 6'b011111};
      tbl[1] = '{4'b0011, 4'b0010, 1'b1, 6'b111000, 6'b111000, 6'b111101};
      tbl[2] = '{4'b1100, 4'b1111, 1'b0, 6'b000000, 6'b000000, 6'b000000};
      tbl[3] = '{4'b0001, 4'b0101, 1'b1, 6'b111000, 6'b111010, 6'b111010};
      tbl[4] = '{4'b0010, 4'b0110, 1'b0, 6'b000000, 6'b000010, 6'b000110};
      tbl[5] = '{4'b1000, 4'b0000, 1'b1, 6'b100000, 6'b100000, 6'b100000};
      for (int k = 0; k < 4; k++) m_state[k] = '0;

      // Reset priority: reset with CE and live carries still yields zero.
      drive(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1);
      tick();
      tick();
      for (int k = 0; k < 4; k++)
         check($sformatf("reset_prio_reg%0d", k), dut_out(k), 6'b000000);
      check("reset_bypass_unaffected", dut_out(4), 6'b111111);
      drive(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1);
      tick();
      check("reset_release_load", dut_out(2), 6'b111111);

      // Vector table
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, tbl[i].am, tbl[i].c, tbl[i].ms);
         #1;
         check($sformatf("vec%0d_bypass", i), dut_out(4), tbl[i].exp_four12);
         tick();
         check($sformatf("vec%0d_one48", i), dut_out(0), tbl[i].exp_one48);
         check($sformatf("vec%0d_two24", i), dut_out(1), tbl[i].exp_two24);
         check($sformatf("vec%0d_four12", i), dut_out(2), tbl[i].exp_four12);
         check($sformatf("vec%0d_simd3", i), dut_out(3), tbl[i].exp_one48);
      end

      // CE hold, then reset with CE low.
      drive(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0);
      tick();
      check("ce_load", dut_out(2), 6'b011111);
      drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
      tick();
      tick();
      check("ce_hold", dut_out(2), 6'b011111);
      check("ce_bypass_unaffected", dut_out(4), 6'b000000);
      drive(1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1);
      tick();
      check_regs("reset_ce_low");
      check("reset_ce_low_four12", dut_out(2), 6'b000000);

      // After reset release with CE low, first load waits for CE.
      drive(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1);
      tick();
      check("release_ce_low", dut_out(2), 6'b000000);
      ce = 1'b1;
      tick();
      check("release_first_load", dut_out(2), 6'b111111);

      // Bypass follows a mid-cycle change within the same cycle.
      drive(1'b1, 1'b0, 4'b0000, 4'b0101, 1'b0);
      #1;
      check("bypass_0101", dut_out(4), 6'b000101);
      #2;
      alu_carry = 4'b1010;
      #1;
      check("bypass_1010", dut_out(4), 6'b011010);
      tick();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 300; n++) begin
         drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)));
         #1;
         check($sformatf("rnd%0d_bypass", n), dut_out(4),
               model_next(2, alumode, alu_carry, mult_sign));
         tick();
         for (int k = 0; k < 4; k++) exp_q.push_back(m_state[k]);
         for (int k = 0; k < 4; k++)
            check($sformatf("rnd%0d_reg%0d", n, k), dut_out(k), exp_q.pop_front());
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
